urv_writeback_ahb: RTL and testbench

- Parametrised next-generation uRV writeback stage.
- Retires ALU, shifter and multiply results plus AHB-Lite load/store data phases into the register file.
- Adds features the previous writeback lacked:
  - registered lane-replicated HWDATA;
  - HRESP two-cycle error handling;
  - bus-timeout watchdog;
  - capture buffer so a data phase that completes under pipeline stall is not lost.
- Sits between execute and the register file.
- Drives the AHB data-phase signals for the core's single data master.

---
 rtl/urv_writeback_ahb.sv | 238 +++++++++++++++++++++++
 tb/tb_urv_writeback_ahb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_writeback_ahb.sv
// rtl/urv_writeback_ahb.sv - uRV writeback stage with AHB-Lite data phase, error/timeout handling and stall capture
module urv_writeback_ahb #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8,
   parameter bit ERR_EN         = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        w_stall_i,
   output logic        w_stall_req_o,
   input  logic        a_store_i,
   input  logic [1:0]  a_fun_i,
   input  logic [31:0] a_store_data_i,
   input  logic [2:0]  x_fun_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic [4:0]  x_rd_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_rd_write_i,
   input  logic        x_valid_i,
   input  logic [31:0] x_shifter_rd_value_i,
   input  logic [31:0] x_multiply_rd_value_i,
   input  logic [2:0]  x_rd_source_i,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic [31:0] HWDATA,
   output logic [31:0] rf_rd_value_o,
   output logic [4:0]  rf_rd_o,
   output logic        rf_rd_write_o,
   output logic        w_exception_o,
   output logic [1:0]  w_exc_cause_o,
   output logic [31:0] w_exc_addr_o
);

   localparam logic [2:0]           SRC_SHIFTER  = 3'b001;
   localparam logic [2:0]           SRC_MULTIPLY = 3'b010;
   localparam logic [TIMEOUT_W:0]   TMO_LIM      = (TIMEOUT_W+1)'(TIMEOUT_CYCLES);
   localparam bit                   TMO_EN       = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR, ST_DONE} state_t;

   state_t               state_q, state_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic [TIMEOUT_W:0]   cnt_inc;
   logic [31:0]          cap_value_q, cap_value_d, cap_addr_q, cap_addr_d;
   logic [4:0]           cap_rd_q, cap_rd_d;
   logic                 cap_write_q, cap_write_d;
   logic [1:0]           cap_cause_q, cap_cause_d;
   logic                 mem, hresp_eff, fin, flt;
   logic [1:0]           flt_cause, bus_err_cause;
   logic [7:0]           load_byte;
   logic [15:0]          load_half;
   logic [31:0]          load_value, result;

   assign mem           = x_valid_i && (x_load_i || x_store_i);
   assign hresp_eff     = ERR_EN && HRESP;
   assign cnt_inc       = {1'b0, cnt_q} + 1'b1;
   assign bus_err_cause = x_load_i ? 2'b01 : 2'b10;

   // Store data is replicated across byte lanes so the slave can pick any lane
   always_ff @(posedge clk_i) begin
      if (rst_i)
         HWDATA <= '0;
      else if (a_store_i && HREADY)
         case (a_fun_i)
            2'b00:   HWDATA <= {4{a_store_data_i[7:0]}};
            2'b01:   HWDATA <= {2{a_store_data_i[15:0]}};
            default: HWDATA <= a_store_data_i;
         endcase
   end

   // Load lane extraction and result source selection
   always_comb begin
      case (x_dm_addr_i[1:0])
         2'b00:   load_byte = HRDATA[7:0];
         2'b01:   load_byte = HRDATA[15:8];
         2'b10:   load_byte = HRDATA[23:16];
         default: load_byte = HRDATA[31:24];
      endcase
      load_half = x_dm_addr_i[1] ? HRDATA[31:16] : HRDATA[15:0];
      case (x_fun_i)
         3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_value = {{16{load_half[15]}}, load_half};
         3'b010:  load_value = HRDATA;
         3'b100:  load_value = {24'b0, load_byte};
         3'b101:  load_value = {16'b0, load_half};
         default: load_value = '0;
      endcase
      if (x_load_i)
         result = load_value;
      else if (x_rd_source_i == SRC_SHIFTER)
         result = x_shifter_rd_value_i;
      else if (x_rd_source_i == SRC_MULTIPLY)
         result = x_multiply_rd_value_i;
      else
         result = x_rd_value_i;
   end

   // State, watchdog counter and capture buffer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cap_value_q <= '0;
         cap_addr_q  <= '0;
         cap_rd_q    <= '0;
         cap_write_q <= 1'b0;
         cap_cause_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_value_q <= cap_value_d;
         cap_addr_q  <= cap_addr_d;
         cap_rd_q    <= cap_rd_d;
         cap_write_q <= cap_write_d;
         cap_cause_q <= cap_cause_d;
      end
   end

   // Next state and outputs; completions/faults under stall are parked in DONE
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cap_value_d   = cap_value_q;
      cap_addr_d    = cap_addr_q;
      cap_rd_d      = cap_rd_q;
      cap_write_d   = cap_write_q;
      cap_cause_d   = cap_cause_q;
      w_stall_req_o = 1'b0;
      rf_rd_write_o = 1'b0;
      rf_rd_value_o = result;
      rf_rd_o       = x_rd_i;
      w_exception_o = 1'b0;
      w_exc_cause_o = 2'b00;
      w_exc_addr_o  = '0;
      fin           = 1'b0;
      flt           = 1'b0;
      flt_cause     = 2'b00;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!mem)
               rf_rd_write_o = x_rd_write_i && x_valid_i && !w_stall_i;
            else if (hresp_eff) begin
               if (HREADY) begin
                  flt       = 1'b1;
                  flt_cause = bus_err_cause;
               end else begin
                  state_d       = ST_ERR;
                  w_stall_req_o = 1'b1;
               end
            end else if (HREADY)
               fin = 1'b1;
            else if (TMO_EN && TMO_LIM == 1) begin
               flt       = 1'b1;
               flt_cause = 2'b11;
            end else begin
               state_d       = ST_WAIT;
               cnt_d         = 1;
               w_stall_req_o = 1'b1;
            end
         end
         ST_WAIT: begin
            if (hresp_eff) begin
               if (HREADY) begin
                  flt       = 1'b1;
                  flt_cause = bus_err_cause;
               end else begin
                  state_d       = ST_ERR;
                  w_stall_req_o = 1'b1;
               end
            end else if (HREADY)
               fin = 1'b1;
            else if (TMO_EN && cnt_inc == TMO_LIM) begin
               flt       = 1'b1;
               flt_cause = 2'b11;
            end else begin
               cnt_d         = cnt_inc[TIMEOUT_W-1:0];
               w_stall_req_o = 1'b1;
            end
         end
         ST_ERR: begin
            if (!HREADY)
               w_stall_req_o = 1'b1;
            else if (hresp_eff) begin
               flt       = 1'b1;
               flt_cause = bus_err_cause;
            end else
               fin = 1'b1;
         end
         default: begin
            rf_rd_o       = cap_rd_q;
            rf_rd_value_o = w_stall_i ? 32'b0 : cap_value_q;
            if (!w_stall_i) begin
               rf_rd_write_o = cap_write_q;
               if (cap_cause_q != 2'b00) begin
                  w_exception_o = 1'b1;
                  w_exc_cause_o = cap_cause_q;
                  w_exc_addr_o  = cap_addr_q;
               end
               state_d = ST_IDLE;
            end
         end
      endcase

      if (fin || flt) begin
         cnt_d = '0;
         if (!w_stall_i) begin
            state_d       = ST_IDLE;
            rf_rd_write_o = fin && x_load_i;
            if (flt) begin
               w_exception_o = 1'b1;
               w_exc_cause_o = flt_cause;
               w_exc_addr_o  = x_dm_addr_i;
            end
         end else begin
            state_d     = ST_DONE;
            cap_value_d = load_value;
            cap_rd_d    = x_rd_i;
            cap_write_d = fin && x_load_i;
            cap_cause_d = flt ? flt_cause : 2'b00;
            cap_addr_d  = x_dm_addr_i;
         end
      end

      if (rst_i) begin
         w_stall_req_o = 1'b0;
         rf_rd_write_o = 1'b0;
         w_exception_o = 1'b0;
         w_exc_cause_o = 2'b00;
         w_exc_addr_o  = '0;
      end
   end

endmodule

// File: tb/tb_urv_writeback_ahb.sv
// tb/tb_urv_writeback_ahb.sv - self-checking bench for urv_writeback_ahb
module tb_urv_writeback_ahb;

   localparam int TMO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i, w_stall_i, a_store_i, x_load_i, x_store_i, x_rd_write_i, x_valid_i;
   logic        HREADY, HRESP;
   logic [1:0]  a_fun_i;
   logic [2:0]  x_fun_i, x_rd_source_i;
   logic [4:0]  x_rd_i;
   logic [31:0] a_store_data_i, x_dm_addr_i, x_rd_value_i, x_shifter_rd_value_i, x_multiply_rd_value_i, HRDATA;

   logic        w_stall_req_o, rf_rd_write_o, w_exception_o;
   logic [1:0]  w_exc_cause_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] HWDATA, rf_rd_value_o, w_exc_addr_o;

   logic        t0_stall_req, t0_write, t0_exc;
   logic [1:0]  t0_cause;
   logic [4:0]  t0_rd;
   logic [31:0] t0_hwdata, t0_value, t0_addr;

   logic        exp_stall, exp_wr, exp_exc, chk_en = 1'b0, chk0_en = 1'b0;
   logic [1:0]  exp_cause;
   logic [4:0]  exp_rd;
   logic [31:0] exp_value, exp_addr, exp_hwdata, m_hw;
   int          errors = 0, checks = 0;

   always #5 clk_i = ~clk_i;

   urv_writeback_ahb #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_W(8), .ERR_EN(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .w_stall_i(w_stall_i), .w_stall_req_o(w_stall_req_o),
      .a_store_i(a_store_i), .a_fun_i(a_fun_i), .a_store_data_i(a_store_data_i),
      .x_fun_i(x_fun_i), .x_load_i(x_load_i), .x_store_i(x_store_i), .x_dm_addr_i(x_dm_addr_i),
      .x_rd_i(x_rd_i), .x_rd_value_i(x_rd_value_i), .x_rd_write_i(x_rd_write_i), .x_valid_i(x_valid_i),
      .x_shifter_rd_value_i(x_shifter_rd_value_i), .x_multiply_rd_value_i(x_multiply_rd_value_i),
      .x_rd_source_i(x_rd_source_i), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .HWDATA(HWDATA), .rf_rd_value_o(rf_rd_value_o), .rf_rd_o(rf_rd_o), .rf_rd_write_o(rf_rd_write_o),
      .w_exception_o(w_exception_o), .w_exc_cause_o(w_exc_cause_o), .w_exc_addr_o(w_exc_addr_o));

   urv_writeback_ahb #(.TIMEOUT_CYCLES(0), .TIMEOUT_W(8), .ERR_EN(1'b1)) dut0 (
      .clk_i(clk_i), .rst_i(rst_i), .w_stall_i(w_stall_i), .w_stall_req_o(t0_stall_req),
      .a_store_i(a_store_i), .a_fun_i(a_fun_i), .a_store_data_i(a_store_data_i),
      .x_fun_i(x_fun_i), .x_load_i(x_load_i), .x_store_i(x_store_i), .x_dm_addr_i(x_dm_addr_i),
      .x_rd_i(x_rd_i), .x_rd_value_i(x_rd_value_i), .x_rd_write_i(x_rd_write_i), .x_valid_i(x_valid_i),
      .x_shifter_rd_value_i(x_shifter_rd_value_i), .x_multiply_rd_value_i(x_multiply_rd_value_i),
      .x_rd_source_i(x_rd_source_i), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .HWDATA(t0_hwdata), .rf_rd_value_o(t0_value), .rf_rd_o(t0_rd), .rf_rd_write_o(t0_write),
      .w_exception_o(t0_exc), .w_exc_cause_o(t0_cause), .w_exc_addr_o(t0_addr));

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] a, input logic [31:0] d);
      logic [31:0] b, h;
      b = (d >> (8 * a)) & 32'hFF;
      h = (d >> (16 * a[1])) & 32'hFFFF;
      case (f)
         3'd0:    return (b >= 32'h80) ? b - 32'h100 : b;
         3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'd2:    return d;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_rep(input logic [1:0] f, input logic [31:0] d);
      if (f == 2'd0) return 32'(d[7:0]) * 32'h01010101;
      if (f == 2'd1) return 32'(d[15:0]) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_result(input logic [2:0] src, input logic [31:0] alu, input logic [31:0] sh, input logic [31:0] mul);
      if (src == 3'd1) return sh;
      if (src == 3'd2) return mul;
      return alu;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // single compare process, sampled mid-cycle
   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("stall_req", 32'(w_stall_req_o), 32'(exp_stall));
         chk("rf_write", 32'(rf_rd_write_o), 32'(exp_wr));
         if (exp_wr) begin
            chk("rf_value", rf_rd_value_o, exp_value);
            chk("rf_rd", 32'(rf_rd_o), 32'(exp_rd));
         end
         chk("exception", 32'(w_exception_o), 32'(exp_exc));
         chk("exc_cause", 32'(w_exc_cause_o), 32'(exp_cause));
         chk("exc_addr", w_exc_addr_o, exp_addr);
         chk("hwdata", HWDATA, exp_hwdata);
      end
      if (chk0_en) begin
         chk("t0_stall_req", 32'(t0_stall_req), 32'd1);
         chk("t0_exception", 32'(t0_exc), 32'd0);
      end
   end

   task automatic exp_clear();
      exp_stall = 0; exp_wr = 0; exp_value = 0; exp_rd = 0;
      exp_exc = 0; exp_cause = 0; exp_addr = 0;
   endtask

   task automatic rand_aphase();
      a_store_i = 1'($urandom_range(0, 1));
      a_fun_i = 2'($urandom_range(0, 3));
      a_store_data_i = $urandom;
   endtask

   task automatic step();
      @(negedge clk_i);
      #1;
      if (rst_i) m_hw = 0;
      else if (a_store_i && HREADY) m_hw = m_rep(a_fun_i, a_store_data_i);
      @(posedge clk_i);
      #1;
      exp_hwdata = m_hw;
   endtask

   task automatic alu_txn();
      rand_aphase();
      x_valid_i = ($urandom_range(0, 3) != 0);
      x_load_i = !x_valid_i && 1'($urandom_range(0, 1));
      x_store_i = 0;
      x_rd_write_i = 1'($urandom_range(0, 1));
      x_rd_source_i = 3'($urandom_range(0, 7));
      x_rd_value_i = $urandom; x_shifter_rd_value_i = $urandom; x_multiply_rd_value_i = $urandom;
      x_rd_i = 5'($urandom); x_fun_i = 3'($urandom); x_dm_addr_i = $urandom;
      w_stall_i = 1'($urandom_range(0, 1));
      HREADY = 1'($urandom_range(0, 1)); HRESP = 1'($urandom_range(0, 1)); HRDATA = $urandom;
      exp_clear();
      exp_wr = x_valid_i && x_rd_write_i && !w_stall_i;
      exp_value = m_result(x_rd_source_i, x_rd_value_i, x_shifter_rd_value_i, x_multiply_rd_value_i);
      exp_rd = x_rd_i;
      step();
   endtask

   // one data-phase transaction: k wait states, optional error (after k waits, j extra ERR cycles), s stall cycles at the end
   task automatic mem_txn(input logic ld, input logic [2:0] f, input int k, input logic err, input int j, input int s);
      logic tmo, ev_wr, ev_exc;
      logic [1:0] ev_cause;
      logic [31:0] ev_value;
      int last;
      x_valid_i = 1; x_load_i = ld; x_store_i = !ld; x_fun_i = f;
      x_dm_addr_i = $urandom; x_rd_i = 5'($urandom); x_rd_write_i = 1'($urandom_range(0, 1));
      x_rd_source_i = 3'($urandom); x_rd_value_i = $urandom;
      x_shifter_rd_value_i = $urandom; x_multiply_rd_value_i = $urandom;
      tmo = !err && k >= TMO;
      last = err ? k + j + 1 : (tmo ? TMO - 1 : k);
      for (int i = 0; i < last; i++) begin
         rand_aphase();
         HREADY = 0; HRESP = err && i >= k; HRDATA = $urandom;
         w_stall_i = 1'($urandom_range(0, 1));
         exp_clear(); exp_stall = 1;
         step();
      end
      rand_aphase();
      HREADY = !tmo; HRESP = err; HRDATA = $urandom;
      ev_wr = !err && !tmo && ld;
      ev_value = m_load(f, x_dm_addr_i[1:0], HRDATA);
      ev_exc = err || tmo;
      ev_cause = tmo ? 2'd3 : (err ? (ld ? 2'd1 : 2'd2) : 2'd0);
      exp_clear();
      for (int i = 0; i < s; i++) begin
         w_stall_i = 1;
         step();
         rand_aphase();
         HREADY = 1'($urandom_range(0, 1)); HRESP = 1'($urandom_range(0, 1)); HRDATA = $urandom;
      end
      w_stall_i = 0;
      exp_wr = ev_wr; exp_value = ev_value; exp_rd = x_rd_i;
      exp_exc = ev_exc; exp_cause = ev_cause; exp_addr = ev_exc ? x_dm_addr_i : 32'h0;
      step();
   endtask

   task automatic rand_txn();
      logic ld;
      if ($urandom_range(0, 9) < 4) alu_txn();
      else begin
         ld = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0)
            mem_txn(ld, 3'($urandom_range(0, 7)), $urandom_range(0, 2), 1'b1, $urandom_range(0, 2), $urandom_range(0, 2));
         else
            mem_txn(ld, 3'($urandom_range(0, 7)), $urandom_range(0, 5), 1'b0, 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
   endtask

   initial begin
      rst_i = 1; w_stall_i = 0; a_store_i = 0; a_fun_i = 0; a_store_data_i = 0;
      x_fun_i = 0; x_load_i = 1; x_store_i = 0; x_dm_addr_i = 0; x_rd_i = 0; x_rd_value_i = 0;
      x_rd_write_i = 1; x_valid_i = 1; x_shifter_rd_value_i = 0; x_multiply_rd_value_i = 0;
      x_rd_source_i = 0; HRDATA = 0; HREADY = 0; HRESP = 0;
      @(posedge clk_i);
      #1;
      m_hw = 0; exp_hwdata = 32'h0; exp_clear(); chk_en = 1;
      step();
      step();
      rst_i = 0;

      // LB / LBU from top byte lane
      x_valid_i = 1; x_load_i = 1; x_store_i = 0; x_fun_i = 3'b000; x_dm_addr_i = 32'h0000_1003;
      x_rd_i = 5'd5; HRDATA = 32'h80FF_FF00; HREADY = 1; HRESP = 0;
      exp_clear(); exp_wr = 1; exp_value = 32'hFFFF_FF80; exp_rd = 5'd5;
      step();
      x_fun_i = 3'b100;
      exp_clear(); exp_wr = 1; exp_value = 32'h0000_0080; exp_rd = 5'd5;
      step();

      // SH replication then hold
      x_valid_i = 0; x_load_i = 0;
      a_store_i = 1; a_fun_i = 2'b01; a_store_data_i = 32'h1234_ABCD; HREADY = 1;
      exp_clear();
      step();
      a_store_i = 0; exp_hwdata = 32'hABCD_ABCD;
      step();
      exp_hwdata = 32'hABCD_ABCD;
      step();

      mem_txn(1'b1, 3'b010, 3, 1'b0, 0, 0);   // LW with 3 wait states
      mem_txn(1'b0, 3'b010, 0, 1'b1, 0, 0);   // store bus error
      mem_txn(1'b1, 3'b010, 9, 1'b0, 0, 0);   // timeout
      mem_txn(1'b1, 3'b010, 0, 1'b0, 0, 2);   // completion under stall
      mem_txn(1'b1, 3'b001, 2, 1'b1, 1, 1);   // load error under stall

      // reset while waiting
      a_store_i = 0; w_stall_i = 0; x_valid_i = 1; x_load_i = 1; x_store_i = 0; HREADY = 0; HRESP = 0;
      exp_clear(); exp_stall = 1;
      step();
      step();
      rst_i = 1; exp_clear();
      step();
      rst_i = 0; x_valid_i = 0; x_load_i = 0; exp_clear();
      step();

      // watchdog disabled: stall persists
      chk_en = 0; chk0_en = 1;
      x_valid_i = 1; x_load_i = 1; HREADY = 0; HRESP = 0;
      for (int i = 0; i < 20; i++) step();
      chk0_en = 0;
      rst_i = 1; x_valid_i = 0; x_load_i = 0;
      step();
      exp_clear(); chk_en = 1;
      step();
      rst_i = 0;

      for (int n = 0; n < 400; n++) rand_txn();

      chk_en = 0;
      @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
